// File: rtl/wb_trace_pkg.sv
// ----------------------------------------------------------------------------
// wb_trace_pkg
// Shared definitions for the writeback trace buffer: default sizes, the
// writeback word type and the rotate helper used by the optional running
// signature (enabled by WB_TRACE_SIG_EN in wb_trace_buffer).
// ----------------------------------------------------------------------------
package wb_trace_pkg;

    localparam int WB_DATA_W = 32;  // writeback data width
    localparam int WB_DEPTH  = 8;   // FIFO entries, power of two, >= 2
    localparam int WB_DROP_W = 8;   // saturating drop counter width

    typedef logic [WB_DATA_W-1:0] wb_word_t;

    // Rotate left by one bit: the MSB wraps into bit 0.
    function automatic wb_word_t rotl1(input wb_word_t w);
        return {w[WB_DATA_W-2:0], w[WB_DATA_W-1]};
    endfunction

endpackage

// File: rtl/wb_trace_buffer_if.sv
// ----------------------------------------------------------------------------
// wb_trace_if
// Groups the core-side writeback strobe and the sink-side ready/valid port
// of the trace buffer.
//   wb_valid / wb_data : core wrote back a value this cycle
//   m_valid  / m_data  : head entry available (show-ahead)
//   m_ready            : sink accepts the head this cycle
// Modports:
//   master : the trace buffer (consumes writebacks, drives the stream)
//   slave  : the environment (drives writebacks, acts as sink)
// ----------------------------------------------------------------------------
interface wb_trace_if #(
    parameter int DATA_W = 32
) ();

    logic              wb_valid;
    logic [DATA_W-1:0] wb_data;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_ready;

    modport master (
        input  wb_valid,
        input  wb_data,
        input  m_ready,
        output m_valid,
        output m_data
    );

    modport slave (
        output wb_valid,
        output wb_data,
        output m_ready,
        input  m_valid,
        input  m_data
    );

endinterface

// File: rtl/wb_trace_fifo.sv
// ----------------------------------------------------------------------------
// wb_trace_fifo
// Generic show-ahead FIFO: storage, read/write pointers, occupancy counter.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_clear     : synchronous flush, wins over push/pop
//   i_push      : write i_data (ignored when full unless popping)
//   i_pop       : drop the head entry (ignored when empty)
//   o_data      : head entry, forced to 0 while empty
//   o_count     : current occupancy
//   o_empty/o_full : occupancy flags
// ----------------------------------------------------------------------------
module wb_trace_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_clear,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [DATA_W-1:0]        i_data,
    output logic [DATA_W-1:0]        o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty,
    output logic                     o_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_pop_ok;
    logic              w_push_ok;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign w_pop_ok  = i_pop && !o_empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    // NOTE: storage has no reset; pointers/count define what is valid, so the
    // array can map onto plain RAM/flops without a reset network.
    always_ff @(posedge clk) begin
        if (w_push_ok && !i_clear) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push_ok && !w_pop_ok)      r_count <= r_count + CNT_W'(1);
            else if (w_pop_ok && !w_push_ok) r_count <= r_count - CNT_W'(1);
        end
    end

    // NOTE: every combinational output gets a value on every path, so no
    // latch can be inferred.
    always_comb begin
        o_data = '0;
        if (!o_empty) o_data = r_mem[r_rd_ptr];
    end

    assign o_count = r_count;

endmodule

// File: rtl/wb_trace_buffer.sv
// ----------------------------------------------------------------------------
// wb_trace_buffer
// Captures the core's per-cycle writeback value into a small FIFO and
// presents it on a ready/valid stream for a slower trace sink. The core is
// never back-pressured: values arriving with no free slot are dropped and
// counted.
// Ports:
//   clk       : system clock
//   reset     : asynchronous active-low reset
//   clear     : synchronous flush of FIFO, drop counter, overflow (and sig)
//   bus       : wb_trace_if.master (wb_valid/wb_data in, m_* stream out)
//   count     : current FIFO occupancy
//   overflow  : sticky, at least one value dropped
//   drop_cnt  : saturating count of dropped values
//   sig       : running signature, only with WB_TRACE_SIG_EN defined
// ----------------------------------------------------------------------------
module wb_trace_buffer
    import wb_trace_pkg::*;
#(
    parameter int DEPTH  = WB_DEPTH,
    parameter int DATA_W = WB_DATA_W,
    parameter int DROP_W = WB_DROP_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    wb_trace_if.master             bus,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
`ifdef WB_TRACE_SIG_EN
    output logic [DATA_W-1:0]      sig,
`endif
    output logic [DROP_W-1:0]      drop_cnt
);

    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_slot;
    logic              w_push;
    logic              w_drop;
    logic              r_overflow;
    logic [DROP_W-1:0] r_drop_cnt;

    assign bus.m_valid = !w_empty;
    assign w_pop       = bus.m_valid && bus.m_ready;
    assign w_slot      = !w_full || w_pop;
    // clear swallows a same-cycle writeback without counting it as a drop.
    assign w_push      = bus.wb_valid && w_slot && !clear;
    assign w_drop      = bus.wb_valid && !w_slot && !clear;

    wb_trace_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_clear (clear),
        .i_push  (w_push),
        .i_pop   (w_pop && !clear),
        .i_data  (bus.wb_data),
        .o_data  (bus.m_data),
        .o_count (count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (clear) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + DROP_W'(1);
        end
    end

    assign overflow = r_overflow;
    assign drop_cnt = r_drop_cnt;

`ifdef WB_TRACE_SIG_EN
    wb_word_t r_sig;

    // Folds in every writeback the core produced, dropped ones included.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sig <= '0;
        end else if (clear) begin
            r_sig <= '0;
        end else if (bus.wb_valid) begin
            r_sig <= rotl1(r_sig) ^ bus.wb_data;
        end
    end

    assign sig = r_sig;
`endif

endmodule

// File: tb/tb_wb_trace_buffer.sv
// ----------------------------------------------------------------------------
// tb_wb_trace_buffer
// Self-checking bench for wb_trace_buffer. A queue-based reference model
// tracks expected contents, drops, overflow and (with WB_TRACE_SIG_EN) the
// signature. Directed scenarios are followed by a randomized run.
// ----------------------------------------------------------------------------
module tb_wb_trace_buffer;
    import wb_trace_pkg::*;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 32;
    localparam int DROP_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              clear;
    logic [3:0]        count;
    logic              overflow;
    logic [DROP_W-1:0] drop_cnt;
`ifdef WB_TRACE_SIG_EN
    logic [DATA_W-1:0] sig;
`endif

    wb_trace_if #(.DATA_W(DATA_W)) bus ();

    wb_trace_buffer #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .DROP_W (DROP_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .bus      (bus),
        .count    (count),
        .overflow (overflow),
`ifdef WB_TRACE_SIG_EN
        .sig      (sig),
`endif
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference model
    wb_word_t    mq[$];
    int          m_drops;
    bit          m_ovf;
    logic [31:0] m_sig;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic model_reset();
        mq.delete();
        m_drops = 0;
        m_ovf   = 1'b0;
        m_sig   = '0;
    endtask

    function automatic logic [31:0] model_head();
        return (mq.size() > 0) ? mq[0] : 32'h0;
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, then
    // settle 1 ns after the edge where outputs are sampled.
    task automatic cycle(input logic wv, input logic [31:0] wd,
                         input logic mr, input logic clr);
        bus.wb_valid = wv;
        bus.wb_data  = wd;
        bus.m_ready  = mr;
        clear        = clr;
        @(posedge clk);
        if (clr) begin
            model_reset();
        end else begin
            if (mr && mq.size() > 0) void'(mq.pop_front());
            if (wv) begin
                if (mq.size() < DEPTH) mq.push_back(wd);
                else begin
                    m_ovf = 1'b1;
                    if (m_drops < 255) m_drops++;
                end
                m_sig = ((m_sig << 1) | (m_sig >> 31)) ^ wd;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear = 1'b0;
        bus.wb_valid = 1'b0;
        bus.wb_data  = '0;
        bus.m_ready  = 1'b0;
        #25;
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b0);
            n_checks++;
            if ({bus.m_valid, bus.m_data, count, overflow, drop_cnt} !== '0) begin
                n_fail++;
                $display("FAIL reset_idle cyc%0d: m_valid=%b m_data=%h count=%0d ovf=%b drop=%0d, expected all 0",
                         i, bus.m_valid, bus.m_data, count, overflow, drop_cnt);
            end
        end
    endtask

    task automatic test_ordering();
        logic [31:0] exp_v [3];
        exp_v[0] = 32'h11; exp_v[1] = 32'h22; exp_v[2] = 32'h33;
        for (int i = 0; i < 3; i++) cycle(1'b1, exp_v[i], 1'b0, 1'b0);
        n_checks++;
        if (count !== 4'd3) begin
            n_fail++;
            $display("FAIL order_count: got %0d expected 3", count);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (bus.m_valid !== 1'b1 || bus.m_data !== exp_v[i]) begin
                n_fail++;
                $display("FAIL order_head%0d: m_valid=%b m_data=%h expected 1/%h",
                         i, bus.m_valid, bus.m_data, exp_v[i]);
            end
            cycle(1'b0, 32'h0, 1'b1, 1'b0);
        end
        n_checks++;
        if (bus.m_valid !== 1'b0 || bus.m_data !== 32'h0) begin
            n_fail++;
            $display("FAIL order_empty: m_valid=%b m_data=%h expected 0/0", bus.m_valid, bus.m_data);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 10; i++) cycle(1'b1, 32'(i), 1'b0, 1'b0);
        n_checks++;
        if (count !== 4'd8 || drop_cnt !== 8'd2 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_state: count=%0d drop=%0d ovf=%b expected 8/2/1", count, drop_cnt, overflow);
        end
        // Head must hold while the sink stalls.
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        n_checks++;
        if (bus.m_data !== 32'h0 || bus.m_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_hold: m_valid=%b m_data=%h expected 1/0", bus.m_valid, bus.m_data);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (bus.m_data !== 32'(i)) begin
                n_fail++;
                $display("FAIL ovf_drain%0d: got %h expected %h", i, bus.m_data, 32'(i));
            end
            cycle(1'b0, 32'h0, 1'b1, 1'b0);
        end
        n_checks++;
        if (bus.m_valid !== 1'b0 || count !== 4'd0) begin
            n_fail++;
            $display("FAIL ovf_empty: m_valid=%b count=%0d expected 0/0", bus.m_valid, count);
        end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] exp_d;
        for (int i = 0; i < 8; i++) cycle(1'b1, 32'(i), 1'b0, 1'b0);
        cycle(1'b1, 32'hAA, 1'b1, 1'b0);
        n_checks++;
        if (count !== 4'd8 || drop_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL full_pp: count=%0d drop=%0d expected 8/2", count, drop_cnt);
        end
        for (int i = 0; i < 8; i++) begin
            exp_d = (i < 7) ? 32'(i + 1) : 32'hAA;
            n_checks++;
            if (bus.m_data !== exp_d) begin
                n_fail++;
                $display("FAIL full_pp_drain%0d: got %h expected %h", i, bus.m_data, exp_d);
            end
            cycle(1'b0, 32'h0, 1'b1, 1'b0);
        end
        n_checks++;
        if (bus.m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL full_pp_empty: m_valid=%b expected 0", bus.m_valid);
        end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'h50 + 32'(i), 1'b0, 1'b0);
        n_checks++;
        if (count !== 4'd5) begin
            n_fail++;
            $display("FAIL clear_pre: count=%0d expected 5", count);
        end
        cycle(1'b1, 32'h77, 1'b1, 1'b1);
        n_checks++;
        if (count !== 4'd0 || bus.m_valid !== 1'b0 || drop_cnt !== 8'd0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_post: count=%0d m_valid=%b drop=%0d ovf=%b expected 0/0/0/0",
                     count, bus.m_valid, drop_cnt, overflow);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b0);
            n_checks++;
            if (bus.m_valid !== 1'b0 || count !== 4'd0) begin
                n_fail++;
                $display("FAIL clear_lost%0d: m_valid=%b count=%0d expected 0/0", i, bus.m_valid, count);
            end
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 300; i++) cycle(1'b1, 32'(i), 1'b0, 1'b0);
        n_checks++;
        if (drop_cnt !== 8'hFF || overflow !== 1'b1 || count !== 4'd8) begin
            n_fail++;
            $display("FAIL sat: drop=%0d ovf=%b count=%0d expected 255/1/8", drop_cnt, overflow, count);
        end
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'hC0 + 32'(i), 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        #3;
        reset = 1'b0;
        #1;
        n_checks++;
        if (count !== 4'd0 || bus.m_valid !== 1'b0 || bus.m_data !== 32'h0) begin
            n_fail++;
            $display("FAIL async_rst: count=%0d m_valid=%b m_data=%h expected 0/0/0",
                     count, bus.m_valid, bus.m_data);
        end
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        cycle(1'b1, 32'h99, 1'b0, 1'b0);
        n_checks++;
        if (count !== 4'd1 || bus.m_data !== 32'h99) begin
            n_fail++;
            $display("FAIL async_first: count=%0d m_data=%h expected 1/99", count, bus.m_data);
        end
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
    endtask

`ifdef WB_TRACE_SIG_EN
    task automatic test_signature();
        cycle(1'b1, 32'hA5A5A5A5, 1'b0, 1'b0);
        n_checks++;
        if (sig !== 32'hA5A5A5A5) begin
            n_fail++;
            $display("FAIL sig_a: got %h expected a5a5a5a5", sig);
        end
        cycle(1'b1, 32'h00000001, 1'b0, 1'b0);
        n_checks++;
        if (sig !== 32'h4B4B4B4A) begin
            n_fail++;
            $display("FAIL sig_b: got %h expected 4b4b4b4a", sig);
        end
        // Restart from reset.
        bus.wb_valid = 1'b0;
        reset = 1'b0;
        #3;
        reset = 1'b1;
        model_reset();
        cycle(1'b1, 32'h1, 1'b0, 1'b0);
        n_checks++;
        if (sig !== 32'h1) begin
            n_fail++;
            $display("FAIL sig_c: got %h expected 00000001", sig);
        end
        cycle(1'b1, 32'h2, 1'b0, 1'b0);
        n_checks++;
        if (sig !== 32'h0) begin
            n_fail++;
            $display("FAIL sig_d: got %h expected 00000000", sig);
        end
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
    endtask
`endif

    task automatic test_random();
        logic        wv;
        logic        mr;
        logic        clr;
        logic [31:0] wd;
        for (int i = 0; i < 600; i++) begin
            wv  = ($urandom_range(0, 3) != 0);
            mr  = ($urandom_range(0, 2) == 0);
            clr = ($urandom_range(0, 79) == 0);
            wd  = $urandom;
            cycle(wv, wd, mr, clr);
            n_checks++;
            if (bus.m_valid !== (mq.size() > 0) || bus.m_data !== model_head() ||
                count !== 4'(mq.size()) || overflow !== m_ovf || drop_cnt !== 8'(m_drops)
`ifdef WB_TRACE_SIG_EN
                || sig !== m_sig
`endif
               ) begin
                n_fail++;
                $display("FAIL rand%0d: v=%b d=%h cnt=%0d ovf=%b drop=%0d expected v=%b d=%h cnt=%0d ovf=%b drop=%0d",
                         i, bus.m_valid, bus.m_data, count, overflow, drop_cnt,
                         (mq.size() > 0), model_head(), mq.size(), m_ovf, m_drops);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ordering();
        test_overflow();
        test_full_push_pop();
        test_clear();
        test_saturation();
        test_async_reset();
`ifdef WB_TRACE_SIG_EN
        test_signature();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_trace_buffer.md
Name: wb_trace_buffer

Overview:
- Sits directly downstream of the riscv core and consumes its per-cycle writeback value (WB_Data) plus a writeback-valid strobe.
- Buffers writeback values in a small FIFO and presents them on a ready/valid master port for a trace sink (debug UART, logger, bench scoreboard).
- Counts values dropped on overflow.
- Decouples the single-cycle core, which never stalls, from a slower consumer.

Parameters:
- DEPTH, 8, FIFO entries; power of two, ≥2.
- DATA_W, 32, writeback data width.
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush: empties the FIFO and zeroes drop_cnt/overflow.
- wb_valid  in  1  core wrote back a value this cycle.
- wb_data  in  DATA_W  core WB_Data.
- m_valid  out  1  head entry available.
- m_data  out  DATA_W  head entry (show-ahead).
- m_ready  in  1  sink accepts head this cycle.
- count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky: at least one value dropped.
- drop_cnt  out  DROP_W  saturating count of dropped values.

Behaviour:
- Reset (reset=0, asynchronous): pointers=0, count=0, m_valid=0, m_data=0, overflow=0, drop_cnt=0. Storage contents are don't-care.
- Push: wb_valid=1 and slot available. Pop: m_valid && m_ready.
- Slot available: count<DEPTH, or count==DEPTH with a pop in the same cycle (simultaneous pop+push when full is accepted; count unchanged).
- Latency: a value pushed at edge N appears on m_data/m_valid after edge N. It is visible from cycle N+1 if the FIFO was empty; there is no bypass combinational path.
- Simultaneous push+pop when empty: the pop is impossible (m_valid=0), so only the push takes effect.
- Drop: wb_valid=1, no slot available. The value is discarded, overflow<=1 and drop_cnt increments, saturating at all-ones.
- m_data holds the head entry while m_valid=1 and m_ready=0. It must not change until popped.
- m_data=0 whenever count==0.
- Pointers are log2(DEPTH) bits and wrap naturally. count is derived from a separate counter.
- clear=1: next edge count=0, m_valid=0, overflow=0, drop_cnt=0.
  - clear has priority over a push or pop in the same cycle; that push is lost and is not counted as a drop.
- Reset asserted mid-operation discards all content immediately (asynchronous). The first push is accepted on the first edge after release.
- No state machine beyond FIFO pointer/count logic.
- The core never sees back-pressure; there is no ready output toward it.

Optional Feature:
- Macro: WB_TRACE_SIG_EN.
- Defined:
  - Adds output port sig (DATA_W), a running signature.
  - On every edge with wb_valid=1 (including dropped values): sig <= rotate_left(sig,1) ^ wb_data.
  - Reset and clear set sig to 0; clear has priority.
  - Allows a bench to compare a whole program's writeback stream in one word.
- Undefined: port and logic are absent.

Decomposition:
- Package wb_trace_pkg:
  - localparam defaults (DATA_W=32, DEPTH=8).
  - typedef wb_word_t (logic [DATA_W-1:0]).
  - function rotl1 for the signature.
- Sub-module wb_trace_fifo: generic storage, pointers, count, full/empty.
- Top wb_trace_buffer adds push qualification, drop/overflow logic, clear priority and the optional signature.

Test Plan:
- Reset then idle: reset low 25 ns, release; no wb_valid → m_valid=0, m_data=0, count=0, overflow=0, drop_cnt=0 for 10 cycles.
- Ordering: push 0x11, 0x22, 0x33 on consecutive cycles with m_ready=0, then m_ready=1.
  - Required: count=3, then m_data=0x11, 0x22, 0x33 on successive cycles; m_valid drops after the third pop.
- Overflow: DEPTH=8, m_ready=0, 10 consecutive pushes of 0..9.
  - Required: count=8, drop_cnt=2, overflow=1; drain yields 0..7.
- Full simultaneous push+pop: FIFO full of 0..7, m_ready=1, push 0xAA.
  - Required: count stays 8, drop_cnt unchanged; drain ends with 0xAA.
- Clear priority: count=5, assert clear with wb_valid=1 and m_ready=1.
  - Required: next cycle count=0, m_valid=0, drop_cnt=0; the pushed value never appears.
- Signature (WB_TRACE_SIG_EN): push 0xA5A5A5A5 then 0x00000001.
  - Required: sig=0xA5A5A5A5, then 0x4B4B4B4A.
  - Also push 0x1 then 0x2 from reset → sig=0x1, then 0x0.
